poly_tone_synth: RTL and testbench
==================================

// Module: poly_tone_synth
// PURPOSE
//  Polyphonic square-wave tone source for the WM8731 audio path. NUM_VOICES key-gated voices,
//  each with a runtime-programmable half-period and a linear attack/release envelope (no key clicks).
//  Voices are mixed into one saturated signed sample per sample tick, which feeds the I2S serialiser.
// PARAMETERS
//  NUM_VOICES   4        voice/key count
//  SAMPLE_W     16       signed output sample width
//  PERIOD_W     20       half-period field width (CLOCK_50 cycles)
//  SAMPLE_DIV   1042     CLOCK_50 cycles per sample tick (~48 kHz)
//  AMP_MAX      16'h2000 envelope ceiling per voice (unsigned, < 2^(SAMPLE_W-1))
//  ATTACK_STEP  16'h0400 envelope increment per tick while key held
//  RELEASE_STEP 16'h0200 envelope decrement per tick while key released
// PORTS
//  CLOCK_50     in  1                     system clock; the only clock
//  reset_n      in  1                     synchronous, active-low reset
//  keys         in  NUM_VOICES            raw async key levels, active high, bit i gates voice i
//  periods      in  NUM_VOICES*PERIOD_W   half-period of voice i in bits [i*PERIOD_W +: PERIOD_W]; 0 = muted
//  sample_out   out SAMPLE_W (signed)     mixed sample, held between ticks
//  sample_valid out 1                     1-cycle pulse when sample_out updates
//  voice_active out NUM_VOICES            bit i = (envelope_i != 0)
// BEHAVIOUR
//  Reset (reset_n=0 at posedge): sample_out=0, sample_valid=0, voice_active=0, all counters/envelopes/tones=0,
//   sync flops=0. Reset mid-note takes effect on the next edge, with no fade.
//  Keys: 2-flop synchroniser per bit; key_s lags keys by 2 cycles.
//  Tick: tick_cnt counts 0..SAMPLE_DIV-1 and wraps; tick=1 in the cycle tick_cnt==SAMPLE_DIV-1.
//  Voice i tone counter (PERIOD_W bits) runs when key_s[i]=1 or env_i!=0:
//   if cnt >= period_i-1: cnt<=0, tone_i<=~tone_i; else cnt<=cnt+1.
//   The >= compare handles a period decrease below the current count: wrap on the next edge.
//   When key_s[i]=0 and env_i=0: cnt<=0, tone_i<=0, so every note starts on the low phase.
//   period_i==0: cnt held 0, tone_i held 0, voice contributes 0. Envelope still runs.
//  Envelope, updated on tick only:
//   - held: env<=min(env+ATTACK_STEP, AMP_MAX)
//   - released: env<=max(env-RELEASE_STEP, 0)
//   - saturating, never wraps
//  Mixer (combinational, width SAMPLE_W+clog2(NUM_VOICES)+1): sum over i of (period_i==0 ? 0 : tone_i ? +env_i : -env_i);
//   clamped to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1].
//  Output: on the tick edge, sample_out<=clamped sum (uses pre-update env/tone) and sample_valid<=1.
//   sample_valid is 0 on every other cycle. First valid sample appears SAMPLE_DIV cycles after reset release.
//  Simultaneous events:
//   - a tick and a tone toggle on the same edge: sample uses the old tone.
//   - key press and release within one tick window: only the key_s value at the tick affects env.
//  voice_active is registered and follows env (reflects the post-update value).
// STRUCTURE
//  audio_synth_pkg:
//   - SAMPLE_W default
//   - SAMPLE_DIV_48K=1042
//   - clog2 function
//   - sat_add helper: signed clamp of wide sum to SAMPLE_W
//  Sub-module tone_voice (one instance per voice via generate):
//   - contains the counter, tone bit and envelope
//   - inputs: CLOCK_50, reset_n, key_s, period, tick
//   - outputs: tone, env
//  The top level holds the synchroniser, tick divider, mixer and output register.
// TESTING (bench overrides: SAMPLE_DIV=8, AMP_MAX=16'h2000, ATTACK_STEP=16'h0400, RELEASE_STEP=16'h0200)
//  1 Reset: keys=4'hF, reset_n=0 for 3 cycles -> sample_out=0, sample_valid=0, voice_active=0; first sample_valid
//    8 cycles after release.
//  2 Attack: period0=4, keys=4'b0001 -> env0 = 0x400,0x800,...,0x2000 after 8 ticks, then stays; tone0 toggles every
//    4 cycles; sample_out in {+env,-env}; voice_active=4'b0001.
//  3 Release: after test 2, keys=0 -> |sample_out| falls by 0x200 per tick; voice_active[0]=0 after 16 ticks;
//    then sample_out=0, tone0=0.
//  4 Saturation: all periods=4, all keys pressed together, held to full -> high phase sum 0x8000 gives sample_out=0x7FFF;
//    low phase gives 0x8000 (exact, no clamp).
//  5 Mute/period change: period1=0 with key1 held -> contributes 0, voice_active[1]=1; change period0 10->3 while cnt=7
//    -> toggle on the next edge, then every 3 cycles.
//  6 Reset mid-note: voices at full, reset_n=0 for 1 cycle -> all outputs 0 on the next edge; attack restarts from 0.

Source files
------------

// File: rtl/audio_synth_pkg.sv
// Shared constants and helpers for the audio synthesis blocks.
package audio_synth_pkg;

  localparam int SAMPLE_W_DEF   = 16;
  localparam int SAMPLE_DIV_48K = 1042;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  // Clamp a wide signed sum into the signed range of a w-bit sample.
  function automatic longint sat_add(input longint sum, input int w);
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -(longint'(1) <<< (w - 1));
    if (sum > hi) return hi;
    if (sum < lo) return lo;
    return sum;
  endfunction

endpackage

// File: rtl/tone_voice.sv
// One square-wave voice: half-period counter, tone bit and linear
// attack/release envelope updated on sample ticks.
module tone_voice #(
  parameter int                  PERIOD_W     = 20,
  parameter int                  ENV_W        = 16,
  parameter logic [ENV_W-1:0]    AMP_MAX      = ENV_W'(32'h2000),
  parameter logic [ENV_W-1:0]    ATTACK_STEP  = ENV_W'(32'h0400),
  parameter logic [ENV_W-1:0]    RELEASE_STEP = ENV_W'(32'h0200)
) (
  input  logic                CLOCK_50,
  input  logic                reset_n,
  input  logic                key_s,
  input  logic [PERIOD_W-1:0] period,
  input  logic                tick,
  output logic                tone,
  output logic [ENV_W-1:0]    env,
  output logic                active
);

  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic                tone_q, tone_d;
  logic [ENV_W-1:0]    env_q, env_d;
  logic                active_q;
  logic [ENV_W:0]      env_up;

  assign env_up = {1'b0, env_q} + {1'b0, ATTACK_STEP};

  always_comb begin
    cnt_d  = cnt_q;
    tone_d = tone_q;
    env_d  = env_q;
    // Idle or muted voices park on the low phase so each note starts low.
    if (period == '0 || (!key_s && env_q == '0)) begin
      cnt_d  = '0;
      tone_d = 1'b0;
    end else if (cnt_q >= period - PERIOD_W'(1)) begin
      cnt_d  = '0;
      tone_d = ~tone_q;
    end else begin
      cnt_d  = cnt_q + PERIOD_W'(1);
    end
    if (tick) begin
      if (key_s)
        env_d = (env_up > {1'b0, AMP_MAX}) ? AMP_MAX : env_up[ENV_W-1:0];
      else
        env_d = (env_q > RELEASE_STEP) ? env_q - RELEASE_STEP : '0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      tone_q   <= 1'b0;
      env_q    <= '0;
      active_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      tone_q   <= tone_d;
      env_q    <= env_d;
      active_q <= (env_d != '0);
    end
  end

  assign tone   = tone_q;
  assign env    = env_q;
  assign active = active_q;

endmodule

// File: rtl/poly_tone_synth.sv
// Polyphonic square-wave source: key synchroniser, sample-tick divider,
// per-voice generators and a saturating mixer with registered output.
module poly_tone_synth
  import audio_synth_pkg::*;
#(
  parameter int                  NUM_VOICES   = 4,
  parameter int                  SAMPLE_W     = SAMPLE_W_DEF,
  parameter int                  PERIOD_W     = 20,
  parameter int                  SAMPLE_DIV   = SAMPLE_DIV_48K,
  parameter logic [SAMPLE_W-1:0] AMP_MAX      = SAMPLE_W'(32'h2000),
  parameter logic [SAMPLE_W-1:0] ATTACK_STEP  = SAMPLE_W'(32'h0400),
  parameter logic [SAMPLE_W-1:0] RELEASE_STEP = SAMPLE_W'(32'h0200)
) (
  input  logic                           CLOCK_50,
  input  logic                           reset_n,
  input  logic [NUM_VOICES-1:0]          keys,
  input  logic [NUM_VOICES*PERIOD_W-1:0] periods,
  output logic signed [SAMPLE_W-1:0]     sample_out,
  output logic                           sample_valid,
  output logic [NUM_VOICES-1:0]          voice_active
);

  localparam int TICK_W = (clog2(SAMPLE_DIV) < 1) ? 1 : clog2(SAMPLE_DIV);
  localparam int MIX_W  = SAMPLE_W + clog2(NUM_VOICES) + 1;

  logic [NUM_VOICES-1:0]               key_m_q, key_s_q;
  logic [TICK_W-1:0]                   tick_cnt_q, tick_cnt_d;
  logic                                tick;
  logic [NUM_VOICES-1:0][PERIOD_W-1:0] period_v;
  logic [NUM_VOICES-1:0][SAMPLE_W-1:0] env_v;
  logic [NUM_VOICES-1:0]               tone_v;
  logic [NUM_VOICES-1:0]               active_v;
  logic signed [MIX_W-1:0]             mix_sum;
  logic signed [SAMPLE_W-1:0]          sample_q, sample_d;
  logic                                valid_q;

  assign period_v   = periods;
  assign tick       = (tick_cnt_q == TICK_W'(SAMPLE_DIV - 1));
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);

  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
    tone_voice #(
      .PERIOD_W    (PERIOD_W),
      .ENV_W       (SAMPLE_W),
      .AMP_MAX     (AMP_MAX),
      .ATTACK_STEP (ATTACK_STEP),
      .RELEASE_STEP(RELEASE_STEP)
    ) u_voice (
      .CLOCK_50(CLOCK_50),
      .reset_n (reset_n),
      .key_s   (key_s_q[i]),
      .period  (period_v[i]),
      .tick    (tick),
      .tone    (tone_v[i]),
      .env     (env_v[i]),
      .active  (active_v[i])
    );
  end

  // Mix uses pre-update tone/env, so a toggle on the tick edge is not seen.
  always_comb begin
    mix_sum = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (period_v[i] != '0) begin
        if (tone_v[i]) mix_sum = mix_sum + $signed(MIX_W'(env_v[i]));
        else           mix_sum = mix_sum - $signed(MIX_W'(env_v[i]));
      end
    end
    sample_d = SAMPLE_W'(sat_add(longint'(mix_sum), SAMPLE_W));
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      key_m_q    <= '0;
      key_s_q    <= '0;
      tick_cnt_q <= '0;
      sample_q   <= '0;
      valid_q    <= 1'b0;
    end else begin
      key_m_q    <= keys;
      key_s_q    <= key_m_q;
      tick_cnt_q <= tick_cnt_d;
      valid_q    <= tick;
      if (tick) sample_q <= sample_d;
    end
  end

  assign sample_out   = sample_q;
  assign sample_valid = valid_q;
  assign voice_active = active_v;

endmodule

// File: tb/tb_poly_tone_synth.sv
// Self-checking bench for poly_tone_synth with a behavioural reference model.
module tb_poly_tone_synth;

  localparam int NV = 4, PW = 20, DIV = 8;
  localparam int AMAX = 'h2000, ATK = 'h400, REL = 'h200;

  logic                 CLOCK_50 = 1'b0;
  logic                 reset_n  = 1'b0;
  logic [NV-1:0]        keys     = '0;
  logic [NV*PW-1:0]     periods  = '0;
  logic signed [15:0]   sample_out;
  logic                 sample_valid;
  logic [NV-1:0]        voice_active;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  poly_tone_synth #(
    .NUM_VOICES(NV), .SAMPLE_W(16), .PERIOD_W(PW), .SAMPLE_DIV(DIV),
    .AMP_MAX(16'h2000), .ATTACK_STEP(16'h0400), .RELEASE_STEP(16'h0200)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .reset_n     (reset_n),
    .keys        (keys),
    .periods     (periods),
    .sample_out  (sample_out),
    .sample_valid(sample_valid),
    .voice_active(voice_active)
  );

  // Reference model: integer arithmetic straight from the behavioural rules.
  logic [NV-1:0]      m_k1, m_k2;
  int                 m_tc;
  int                 m_cnt[NV];
  bit                 m_tone[NV];
  int                 m_env[NV];
  int                 m_envn[NV];
  logic signed [15:0] m_samp;
  logic               m_valid;
  logic [NV-1:0]      m_act;
  bit                 m_tick;
  int                 m_mix;

  always_comb begin
    m_tick = (m_tc == DIV - 1);
    m_mix  = 0;
    for (int v = 0; v < NV; v++) begin
      if (m_k2[v]) m_envn[v] = (m_env[v] + ATK > AMAX) ? AMAX : m_env[v] + ATK;
      else         m_envn[v] = (m_env[v] < REL) ? 0 : m_env[v] - REL;
      if (periods[v*PW +: PW] != 0) m_mix += m_tone[v] ? m_env[v] : -m_env[v];
    end
    if (m_mix > 32767) m_mix = 32767;
    else if (m_mix < -32768) m_mix = -32768;
  end

  always @(posedge CLOCK_50) begin
    if (!reset_n) begin
      m_k1 <= '0; m_k2 <= '0; m_tc <= 0; m_samp <= '0; m_valid <= 1'b0; m_act <= '0;
      for (int v = 0; v < NV; v++) begin
        m_cnt[v] <= 0; m_tone[v] <= 1'b0; m_env[v] <= 0;
      end
    end else begin
      m_k1    <= keys;
      m_k2    <= m_k1;
      m_tc    <= m_tick ? 0 : m_tc + 1;
      m_valid <= m_tick;
      if (m_tick) m_samp <= 16'(m_mix);
      for (int v = 0; v < NV; v++) begin
        if (periods[v*PW +: PW] == 0 || (!m_k2[v] && m_env[v] == 0)) begin
          m_cnt[v] <= 0; m_tone[v] <= 1'b0;
        end else if (m_cnt[v] >= int'(periods[v*PW +: PW]) - 1) begin
          m_cnt[v] <= 0; m_tone[v] <= !m_tone[v];
        end else begin
          m_cnt[v] <= m_cnt[v] + 1;
        end
        if (m_tick) begin
          m_env[v] <= m_envn[v];
          m_act[v] <= (m_envn[v] != 0);
        end
      end
    end
  end

  task automatic apply_reset();
    reset_n = 1'b0;
    @(negedge CLOCK_50);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    int lat;
    keys = 4'hF;
    for (int v = 0; v < NV; v++) periods[v*PW +: PW] = PW'($urandom_range(1, 12));
    reset_n = 1'b0;
    repeat (3) begin
      @(negedge CLOCK_50);
      n_assert++;
      if ({sample_out, sample_valid, voice_active} !== 21'd0) begin
        n_fail++;
        $display("FAIL reset_state got out=%h vld=%b act=%b want 0/0/0", sample_out, sample_valid, voice_active);
      end
    end
    reset_n = 1'b1;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge CLOCK_50);
      n_assert++;
      if ({sample_out, sample_valid, voice_active} !== {m_samp, m_valid, m_act}) begin
        n_fail++;
        $display("FAIL reset_model got %h/%b/%b want %h/%b/%b", sample_out, sample_valid, voice_active, m_samp, m_valid, m_act);
      end
      if (sample_valid) begin lat = k; break; end
    end
    n_assert++;
    if (lat !== 8) begin
      n_fail++;
      $display("FAIL first_valid_latency got %0d want 8", lat);
    end
  endtask

  task automatic test_attack();
    int j, s, a, e;
    keys = '0;
    periods = '0;
    periods[0 +: PW] = PW'(4);
    for (int v = 1; v < NV; v++) periods[v*PW +: PW] = PW'($urandom_range(1, 12));
    reset_n = 1'b0;
    @(negedge CLOCK_50);
    reset_n = 1'b1;
    keys = 4'b0001;
    j = 0;
    for (int c = 0; c < 200 && j < 12; c++) begin
      @(negedge CLOCK_50);
      n_assert++;
      if ({sample_out, sample_valid, voice_active} !== {m_samp, m_valid, m_act}) begin
        n_fail++;
        $display("FAIL attack_model got %h/%b/%b want %h/%b/%b", sample_out, sample_valid, voice_active, m_samp, m_valid, m_act);
      end
      if (sample_valid) begin
        j++;
        s = sample_out;
        a = (s < 0) ? -s : s;
        e = (ATK * (j - 1) > AMAX) ? AMAX : ATK * (j - 1);
        n_assert++;
        if (a != e || voice_active !== 4'b0001) begin
          n_fail++;
          $display("FAIL attack_env tick %0d got |out|=%h act=%b want %h act=0001", j, a, voice_active, e);
        end
      end
    end
    n_assert++;
    if (j != 12) begin n_fail++; $display("FAIL attack_ticks got %0d want 12", j); end
  endtask

  task automatic test_release();
    int j, s, a, prev, act_cnt;
    keys = '0;
    prev = AMAX;
    act_cnt = 0;
    j = 0;
    for (int c = 0; c < 400 && j < 20; c++) begin
      @(negedge CLOCK_50);
      n_assert++;
      if ({sample_out, sample_valid, voice_active} !== {m_samp, m_valid, m_act}) begin
        n_fail++;
        $display("FAIL release_model got %h/%b/%b want %h/%b/%b", sample_out, sample_valid, voice_active, m_samp, m_valid, m_act);
      end
      if (sample_valid) begin
        j++;
        s = sample_out;
        a = (s < 0) ? -s : s;
        if (voice_active[0]) act_cnt++;
        if (a < prev) begin
          n_assert++;
          if (prev - a != REL) begin
            n_fail++;
            $display("FAIL release_step tick %0d got step %h want %h", j, prev - a, REL);
          end
        end
        prev = a;
      end
    end
    n_assert++;
    if (sample_out !== 16'sd0 || voice_active !== 4'b0000 || act_cnt != 15) begin
      n_fail++;
      $display("FAIL release_end got out=%h act=%b act_ticks=%0d want 0000/0000/15", sample_out, voice_active, act_cnt);
    end
  endtask

  task automatic test_saturation();
    int j;
    bit saw_hi, saw_lo;
    for (int v = 0; v < NV; v++) periods[v*PW +: PW] = PW'(4);
    keys = '0;
    apply_reset();
    keys = 4'hF;
    j = 0;
    for (int c = 0; c < 400 && j < 14; c++) begin
      @(negedge CLOCK_50);
      n_assert++;
      if ({sample_out, sample_valid, voice_active} !== {m_samp, m_valid, m_act}) begin
        n_fail++;
        $display("FAIL sat_model got %h/%b/%b want %h/%b/%b", sample_out, sample_valid, voice_active, m_samp, m_valid, m_act);
      end
      if (sample_valid) begin
        j++;
        if (j >= 11) begin
          n_assert++;
          if (sample_out !== 16'sh7FFF || voice_active !== 4'hF) begin
            n_fail++;
            $display("FAIL sat_high got %h act=%b want 7fff act=f", sample_out, voice_active);
          end
        end
      end
    end
    for (int v = 0; v < NV; v++) periods[v*PW +: PW] = PW'(5);
    saw_hi = 1'b0; saw_lo = 1'b0; j = 0;
    for (int c = 0; c < 400 && j < 12; c++) begin
      @(negedge CLOCK_50);
      if (sample_valid) begin
        j++;
        if (sample_out === 16'sh7FFF) saw_hi = 1'b1;
        if (sample_out === 16'sh8000) saw_lo = 1'b1;
        n_assert++;
        if (sample_out !== 16'sh7FFF && sample_out !== 16'sh8000) begin
          n_fail++;
          $display("FAIL sat_range got %h want 7fff or 8000", sample_out);
        end
      end
    end
    n_assert++;
    if (!(saw_hi && saw_lo)) begin
      n_fail++;
      $display("FAIL sat_both_phases got hi=%b lo=%b want 1/1", saw_hi, saw_lo);
    end
  endtask

  task automatic test_mute_period();
    int j, s, a;
    bit found;
    keys = '0;
    periods = '0;
    periods[0 +: PW] = PW'(10);
    periods[2*PW +: PW] = PW'($urandom_range(1, 12));
    periods[3*PW +: PW] = PW'($urandom_range(1, 12));
    apply_reset();
    keys = 4'b0011;
    j = 0;
    for (int c = 0; c < 400 && j < 12; c++) begin
      @(negedge CLOCK_50);
      n_assert++;
      if ({sample_out, sample_valid, voice_active} !== {m_samp, m_valid, m_act}) begin
        n_fail++;
        $display("FAIL mute_model got %h/%b/%b want %h/%b/%b", sample_out, sample_valid, voice_active, m_samp, m_valid, m_act);
      end
      if (sample_valid) begin
        j++;
        s = sample_out;
        a = (s < 0) ? -s : s;
        if (j >= 10) begin
          n_assert++;
          if (a != AMAX || voice_active !== 4'b0011) begin
            n_fail++;
            $display("FAIL mute_contrib got |out|=%h act=%b want 2000 act=0011", a, voice_active);
          end
        end
      end
    end
    found = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge CLOCK_50);
      if (m_cnt[0] == 7) begin found = 1'b1; break; end
    end
    n_assert++;
    if (!found) begin n_fail++; $display("FAIL period_change_setup got no cnt==7 want cnt==7"); end
    periods[0 +: PW] = PW'(3);
    repeat (120) begin
      @(negedge CLOCK_50);
      n_assert++;
      if ({sample_out, sample_valid, voice_active} !== {m_samp, m_valid, m_act}) begin
        n_fail++;
        $display("FAIL period_change_model got %h/%b/%b want %h/%b/%b", sample_out, sample_valid, voice_active, m_samp, m_valid, m_act);
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    for (int v = 0; v < NV; v++) periods[v*PW +: PW] = PW'($urandom_range(1, 12));
    keys = 4'hF;
    repeat (12 * DIV) @(negedge CLOCK_50);
    n_assert++;
    if (voice_active !== 4'hF) begin
      n_fail++;
      $display("FAIL midreset_pre got act=%b want f", voice_active);
    end
    reset_n = 1'b0;
    @(negedge CLOCK_50);
    n_assert++;
    if ({sample_out, sample_valid, voice_active} !== 21'd0) begin
      n_fail++;
      $display("FAIL midreset_clear got %h/%b/%b want 0/0/0", sample_out, sample_valid, voice_active);
    end
    reset_n = 1'b1;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge CLOCK_50);
      n_assert++;
      if ({sample_out, sample_valid, voice_active} !== {m_samp, m_valid, m_act}) begin
        n_fail++;
        $display("FAIL midreset_model got %h/%b/%b want %h/%b/%b", sample_out, sample_valid, voice_active, m_samp, m_valid, m_act);
      end
      if (sample_valid) begin lat = k; break; end
    end
    n_assert++;
    if (lat != 8 || sample_out !== 16'sd0 || voice_active !== 4'hF) begin
      n_fail++;
      $display("FAIL midreset_restart got lat=%0d out=%h act=%b want 8/0000/f", lat, sample_out, voice_active);
    end
  endtask

  task automatic test_back_to_back();
    keys = '0;
    apply_reset();
    repeat (800) begin
      if ($urandom_range(0, 5) == 0) keys = 4'($urandom);
      if ($urandom_range(0, 19) == 0) periods[$urandom_range(0, NV-1)*PW +: PW] = PW'($urandom_range(0, 12));
      @(negedge CLOCK_50);
      n_assert++;
      if ({sample_out, sample_valid, voice_active} !== {m_samp, m_valid, m_act}) begin
        n_fail++;
        $display("FAIL random_model got %h/%b/%b want %h/%b/%b", sample_out, sample_valid, voice_active, m_samp, m_valid, m_act);
      end
    end
  endtask

  initial begin
    test_reset();
    test_attack();
    test_release();
    test_saturation();
    test_mute_period();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
